// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared opcode constants and issue-stage state encoding
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_HALTED    = 2'd2
    } issue_state_e;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - immediate forms derived from the low instruction bits
module imm_gen #(
    parameter int DW = 16
) (
    input  logic [8:0]    imm_field,
    output logic [DW-1:0] imm4,
    output logic [DW-1:0] offset,
    output logic [DW-1:0] imm8,
    output logic [DW-1:0] imm9
);

    // Shift amount, halfword memory offset, byte immediate, halfword branch offset.
    assign imm4   = {{(DW-4){1'b0}}, imm_field[3:0]};
    assign offset = {{(DW-5){imm_field[3]}}, imm_field[3:0], 1'b0};
    assign imm8   = {{(DW-8){1'b0}}, imm_field[7:0]};
    assign imm9   = {{(DW-10){imm_field[8]}}, imm_field[8:0], 1'b0};

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode/issue stage with output register and halt sequencing
module alu_issue
    import wisc_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [RW-1:0] ra_addr,
    output logic [RW-1:0] rb_addr,
    input  logic [DW-1:0] ra_data,
    input  logic [DW-1:0] rb_data,
    input  logic          flush,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [DW-1:0] ALU_In1,
    output logic [DW-1:0] ALU_In2,
    output logic [3:0]    Opcode,
    output logic [2:0]    cond,
    output logic [DW-1:0] store_data,
    output logic [RW-1:0] wr_reg,
    output logic          wr_en,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          halted
);

    issue_state_e state;

    logic [3:0]    op;
    logic [RW-1:0] rd, rs, rt;
    logic [DW-1:0] imm4, offset, imm8, imm9;
    logic [DW-1:0] d_in1, d_in2, d_store;
    logic          d_wr_en, d_mem_rd, d_mem_wr;
    logic          accept;

    assign op = instr[15:12];
    assign rd = instr[11:8];
    assign rs = instr[7:4];
    assign rt = instr[3:0];

    // LLB/LHB modify rd in place, SW reads its data register from rd.
    assign ra_addr = (op == OP_LLB || op == OP_LHB) ? rd : rs;
    assign rb_addr = (op == OP_SW) ? rd : rt;

    assign instr_ready = (state == ST_RUN) && !flush && (!ex_valid || ex_ready);
    assign accept      = instr_valid && instr_ready;
    assign halted      = (state == ST_HALTED);

    imm_gen #(.DW(DW)) u_imm_gen (
        .imm_field (instr[8:0]),
        .imm4      (imm4),
        .offset    (offset),
        .imm8      (imm8),
        .imm9      (imm9)
    );

    // Form the ALU operands and side-effect strobes for the offered instruction.
    always_comb begin
        d_in1    = ra_data;
        d_in2    = '0;
        d_store  = '0;
        d_wr_en  = 1'b0;
        d_mem_rd = 1'b0;
        d_mem_wr = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                d_in2   = rb_data;
                d_wr_en = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                d_in2   = imm4;
                d_wr_en = 1'b1;
            end
            OP_LW: begin
                d_in2    = offset;
                d_mem_rd = 1'b1;
                d_wr_en  = 1'b1;
            end
            OP_SW: begin
                d_in2    = offset;
                d_mem_wr = 1'b1;
                d_store  = rb_data;
            end
            OP_LLB, OP_LHB: begin
                d_in2   = imm8;
                d_wr_en = 1'b1;
            end
            OP_B: begin
                d_in1 = '0;
                d_in2 = imm9;
            end
            OP_BR: begin
                d_in2 = '0;
            end
            OP_PCS: begin
                d_in1   = '0;
                d_wr_en = 1'b1;
            end
            default: begin
                d_in1 = '0;
            end
        endcase
    end

    // Halt sequencing: HLT waits in the output register until execute takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept && op == OP_HLT) state <= ST_HALT_PEND;
                end
                ST_HALT_PEND: begin
                    if (flush)                     state <= ST_RUN;
                    else if (ex_valid && ex_ready) state <= ST_HALTED;
                end
                default: state <= ST_HALTED;
            endcase
        end
    end

    // Slot occupancy: flush kills it, accept fills it, consume empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
        end else if (flush && state != ST_HALTED) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // Payload only changes on accept, so it holds steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_In1    <= '0;
            ALU_In2    <= '0;
            Opcode     <= '0;
            cond       <= '0;
            store_data <= '0;
            wr_reg     <= '0;
            wr_en      <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
        end else if (accept) begin
            ALU_In1    <= d_in1;
            ALU_In2    <= d_in2;
            Opcode     <= op;
            cond       <= instr[11:9];
            store_data <= d_store;
            wr_reg     <= rd;
            wr_en      <= d_wr_en;
            mem_rd     <= d_mem_rd;
            mem_wr     <= d_mem_wr;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  ra_addr, rb_addr;
    logic [15:0] ra_data, rb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ALU_In1, ALU_In2, store_data;
    logic [3:0]  Opcode, wr_reg;
    logic [2:0]  cond;
    logic        wr_en, mem_rd, mem_wr, halted;

    logic [15:0] regs [16];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] in1, in2, store;
        logic [3:0]  op, wr_reg, ra, rb;
        logic [2:0]  cond;
        logic        wr_en, mem_rd, mem_wr;
    } exp_t;

    exp_t q [$];

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data), .flush(flush), .ex_valid(ex_valid),
        .ex_ready(ex_ready), .ALU_In1(ALU_In1), .ALU_In2(ALU_In2), .Opcode(Opcode),
        .cond(cond), .store_data(store_data), .wr_reg(wr_reg), .wr_en(wr_en),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] ins);
        exp_t e;
        int o, rd, rs, rt, a, b, i4, s4, i9, s9;
        o  = int'(ins[15:12]);
        rd = int'(ins[11:8]);
        rs = int'(ins[7:4]);
        rt = int'(ins[3:0]);
        a  = (o == 10 || o == 11) ? rd : rs;
        b  = (o == 9) ? rd : rt;
        i4 = int'(ins[3:0]);
        s4 = (i4 >= 8) ? i4 - 16 : i4;
        i9 = int'(ins[8:0]);
        s9 = (i9 >= 256) ? i9 - 512 : i9;
        e.op = ins[15:12]; e.cond = ins[11:9]; e.wr_reg = ins[11:8];
        e.ra = 4'(a); e.rb = 4'(b);
        e.in1 = 16'h0; e.in2 = 16'h0; e.store = 16'h0;
        e.wr_en = 1'b0; e.mem_rd = 1'b0; e.mem_wr = 1'b0;
        if (o <= 3 || o == 7) begin
            e.in1 = regs[a]; e.in2 = regs[b]; e.wr_en = 1'b1;
        end else if (o <= 6) begin
            e.in1 = regs[a]; e.in2 = 16'(i4); e.wr_en = 1'b1;
        end else if (o == 8) begin
            e.in1 = regs[a]; e.in2 = 16'(s4 * 2); e.mem_rd = 1'b1; e.wr_en = 1'b1;
        end else if (o == 9) begin
            e.in1 = regs[a]; e.in2 = 16'(s4 * 2); e.mem_wr = 1'b1; e.store = regs[b];
        end else if (o == 10 || o == 11) begin
            e.in1 = regs[a]; e.in2 = 16'(int'(ins[7:0])); e.wr_en = 1'b1;
        end else if (o == 12) begin
            e.in2 = 16'(s9 * 2);
        end else if (o == 13) begin
            e.in1 = regs[a];
        end else if (o == 14) begin
            e.wr_en = 1'b1;
        end
        return e;
    endfunction

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({ex_valid, halted, wr_en, mem_rd, mem_wr} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {ex_valid, halted, wr_en, mem_rd, mem_wr});
        end
        checks++;
        if ({ALU_In1, ALU_In2, store_data, Opcode, wr_reg, cond} !== 59'h0) begin
            errors++; $display("FAIL reset_payload got=%h exp=0", {ALU_In1, ALU_In2, store_data, Opcode, wr_reg, cond});
        end
        #2;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b exp=1", instr_ready);
        end
    endtask

    task automatic test_add();
        regs[1] = 16'h0005; regs[2] = 16'h0007;
        @(posedge clk); #1;
        instr = 16'h0312; instr_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0;
        #2;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL add_ready got=%b exp=1", instr_ready);
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checks++;
        if ({ex_valid, Opcode, ALU_In1, ALU_In2, wr_reg, wr_en} !== {1'b1, 4'h0, 16'h0005, 16'h0007, 4'h3, 1'b1}) begin
            errors++; $display("FAIL add_out got=%h exp=%h", {ex_valid, Opcode, ALU_In1, ALU_In2, wr_reg, wr_en},
                               {1'b1, 4'h0, 16'h0005, 16'h0007, 4'h3, 1'b1});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sw();
        regs[2] = 16'h1000; regs[4] = 16'hBEEF;
        @(posedge clk); #1;
        instr = 16'h942F; instr_valid = 1'b1; ex_ready = 1'b1;
        #2;
        checks++;
        if ({ra_addr, rb_addr} !== 8'h24) begin
            errors++; $display("FAIL sw_addr got=%h exp=24", {ra_addr, rb_addr});
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checks++;
        if ({ex_valid, ALU_In1, ALU_In2, store_data, mem_wr, wr_en, mem_rd} !==
            {1'b1, 16'h1000, 16'hFFFE, 16'hBEEF, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sw_out got=%h exp=%h", {ex_valid, ALU_In1, ALU_In2, store_data, mem_wr, wr_en, mem_rd},
                               {1'b1, 16'h1000, 16'hFFFE, 16'hBEEF, 1'b1, 1'b0, 1'b0});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        regs[1] = 16'h0005; regs[2] = 16'h0007;
        @(posedge clk); #1;
        instr = 16'h0312; instr_valid = 1'b1; ex_ready = 1'b0;
        @(posedge clk); #1;
        instr = 16'h1521;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (instr_ready !== 1'b0) begin
                errors++; $display("FAIL b2b_stall_ready cyc=%0d got=%b exp=0", i, instr_ready);
            end
            @(posedge clk); #1;
            checks++;
            if ({ex_valid, Opcode, ALU_In1, ALU_In2} !== {1'b1, 4'h0, 16'h0005, 16'h0007}) begin
                errors++; $display("FAIL b2b_hold cyc=%0d got=%h exp=%h", i, {ex_valid, Opcode, ALU_In1, ALU_In2},
                                   {1'b1, 4'h0, 16'h0005, 16'h0007});
            end
        end
        ex_ready = 1'b1;
        #2;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_release_ready got=%b exp=1", instr_ready);
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checks++;
        if ({ex_valid, Opcode, ALU_In1, ALU_In2, wr_reg} !== {1'b1, 4'h1, 16'h0007, 16'h0005, 4'h5}) begin
            errors++; $display("FAIL b2b_sub got=%h exp=%h", {ex_valid, Opcode, ALU_In1, ALU_In2, wr_reg},
                               {1'b1, 4'h1, 16'h0007, 16'h0005, 4'h5});
        end
        @(posedge clk); #1;
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got=%b exp=0", ex_valid);
        end
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        instr = 16'h0312; instr_valid = 1'b1; ex_ready = 1'b0;
        @(posedge clk); #1;
        instr = 16'h1521; flush = 1'b1;
        #2;
        checks++;
        if ({ex_valid, instr_ready} !== 2'b10) begin
            errors++; $display("FAIL flush_ready got=%b exp=10", {ex_valid, instr_ready});
        end
        @(posedge clk); #1;
        flush = 1'b0; instr_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++; $display("FAIL flush_kill got=%b exp=0", ex_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_accept got=%b exp=0", ex_valid);
        end
        ex_ready = 1'b1;
    endtask

    task automatic test_random();
        exp_t e, h;
        logic exp_ready;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ex_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid it=%0d got=%b exp=%b", i, ex_valid, q.size() != 0);
            end
            regs[$urandom_range(15)] = 16'($urandom);
            instr       = {4'($urandom_range(14)), 12'($urandom)};
            instr_valid = ($urandom_range(3) != 0);
            ex_ready    = ($urandom_range(2) != 0);
            #2;
            e = model(instr);
            exp_ready = (q.size() == 0) || ex_ready;
            checks++;
            if ({instr_ready, ra_addr, rb_addr} !== {exp_ready, e.ra, e.rb}) begin
                errors++; $display("FAIL rnd_ready_addr it=%0d got=%h exp=%h", i, {instr_ready, ra_addr, rb_addr}, {exp_ready, e.ra, e.rb});
            end
            if (q.size() != 0 && ex_ready) begin
                h = q.pop_front();
                checks++;
                if ({ALU_In1, ALU_In2, Opcode, cond, wr_en, mem_rd, mem_wr} !==
                    {h.in1, h.in2, h.op, h.cond, h.wr_en, h.mem_rd, h.mem_wr} ||
                    (h.wr_en && wr_reg !== h.wr_reg) || (h.mem_wr && store_data !== h.store)) begin
                    errors++; $display("FAIL rnd_payload it=%0d got=%h/%h/%h exp=%h/%h/%h", i,
                                       {ALU_In1, ALU_In2, Opcode, cond, wr_en, mem_rd, mem_wr}, wr_reg, store_data,
                                       {h.in1, h.in2, h.op, h.cond, h.wr_en, h.mem_rd, h.mem_wr}, h.wr_reg, h.store);
                end
            end
            if (instr_valid && exp_ready) q.push_back(e);
        end
        @(posedge clk); #1;
        instr_valid = 1'b0; ex_ready = 1'b1;
        @(posedge clk); #1;
        q.delete();
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_drain got=%b exp=0", ex_valid);
        end
    endtask

    task automatic test_halt();
        @(posedge clk); #1;
        instr = 16'hF000; instr_valid = 1'b1; ex_ready = 1'b0;
        @(posedge clk); #1;
        instr = 16'h0312;
        checks++;
        if ({ex_valid, Opcode, wr_en, mem_rd, mem_wr} !== {1'b1, 4'hF, 3'b000}) begin
            errors++; $display("FAIL hlt_out got=%h exp=%h", {ex_valid, Opcode, wr_en, mem_rd, mem_wr}, {1'b1, 4'hF, 3'b000});
        end
        #2;
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++; $display("FAIL hlt_pend_ready got=%b exp=0", instr_ready);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_ready = 1'b1;
        #2;
        checks++;
        if ({ex_valid, halted, instr_ready} !== 3'b001) begin
            errors++; $display("FAIL hlt_flush_run got=%b exp=001", {ex_valid, halted, instr_ready});
        end
        @(posedge clk); #1;
        instr = 16'hF000;
        @(posedge clk); #1;
        instr = 16'h0312; ex_ready = 1'b0;
        checks++;
        if ({ex_valid, Opcode, halted} !== {1'b1, 4'hF, 1'b0}) begin
            errors++; $display("FAIL hlt_held got=%h exp=%h", {ex_valid, Opcode, halted}, {1'b1, 4'hF, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 2) ex_ready = 1'b1;
            #2;
            checks++;
            if (instr_ready !== 1'b0) begin
                errors++; $display("FAIL hlt_block cyc=%0d got=%b exp=0", i, instr_ready);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({halted, ex_valid} !== 2'b10) begin
            errors++; $display("FAIL hlt_halted got=%b exp=10", {halted, ex_valid});
        end
        flush = 1'b1;
        #2;
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++; $display("FAIL hlt_halted_ready got=%b exp=0", instr_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({halted, ex_valid} !== 2'b10) begin
            errors++; $display("FAIL hlt_flush_ignored got=%b exp=10", {halted, ex_valid});
        end
    endtask

    task automatic test_async_reset();
        instr_valid = 1'b0; ex_ready = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({halted, ex_valid} !== 2'b00) begin
            errors++; $display("FAIL arst_halted got=%b exp=00", {halted, ex_valid});
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        instr = 16'h0312; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b1) begin
            errors++; $display("FAIL arst_stall_setup got=%b exp=1", ex_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_valid, halted, ALU_In1} !== {2'b00, 16'h0}) begin
            errors++; $display("FAIL arst_drop got=%h exp=0", {ex_valid, halted, ALU_In1});
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        ex_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'(i * 16'h1111);
        rst_n = 1'b0; instr = 16'h0; instr_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        #23 rst_n = 1'b1;
        test_reset();
        test_add();
        test_sw();
        test_back_to_back();
        test_flush();
        test_random();
        test_halt();
        test_async_reset();
        test_add();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
